// File: rtl/alu_pkg.sv
// Shared ALU definitions: operation codes, RV32I opcodes and the issue payload.
// Used by alu_issue and its skid buffer.
package alu_pkg;

    localparam int DATA_W = 32;
    localparam int OP_W   = 4;

    localparam logic [OP_W-1:0] ALU_AND     = 4'b0000;
    localparam logic [OP_W-1:0] ALU_OR      = 4'b0001;
    localparam logic [OP_W-1:0] ALU_ADD     = 4'b0010;
    localparam logic [OP_W-1:0] ALU_SUB     = 4'b0011;
    localparam logic [OP_W-1:0] ALU_PASS1   = 4'b0101;
    localparam logic [OP_W-1:0] ALU_XOR     = 4'b0110;
    localparam logic [OP_W-1:0] ALU_EQ      = 4'b1000;
    localparam logic [OP_W-1:0] ALU_NE      = 4'b1001;
    localparam logic [OP_W-1:0] ALU_LT      = 4'b1010;
    localparam logic [OP_W-1:0] ALU_GE      = 4'b1011;
    localparam logic [OP_W-1:0] ALU_ILLEGAL = 4'b1111;

    localparam logic [6:0] OPC_RTYPE  = 7'b0110011;
    localparam logic [6:0] OPC_IALU   = 7'b0010011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    typedef struct packed {
        logic [DATA_W-1:0] srca;
        logic [DATA_W-1:0] srcb;
        logic [OP_W-1:0]   op;
    } alu_req_t;

    // An illegal request travels as a zero-operand ILLEGAL op so the ALU yields 0.
    function automatic alu_req_t illegal_req();
        alu_req_t r;
        r.srca = {DATA_W{1'b0}};
        r.srcb = {DATA_W{1'b0}};
        r.op   = ALU_ILLEGAL;
        return r;
    endfunction

endpackage

// File: rtl/alu_issue_if.sv
// Upstream request / downstream ALU bus of the issue stage.
// master = the side that issues requests and consumes results, slave = alu_issue.
interface alu_issue_if #(
    parameter int DATA_WIDTH    = 32,
    parameter int OPCODE_LENGTH = 4
);
    logic                     in_valid;
    logic                     in_ready;
    logic [6:0]               opcode;
    logic [2:0]               funct3;
    logic [6:0]               funct7;
    logic [DATA_WIDTH-1:0]    rs1_data;
    logic [DATA_WIDTH-1:0]    rs2_data;
    logic [DATA_WIDTH-1:0]    imm;
    logic                     out_valid;
    logic                     out_ready;
    logic [DATA_WIDTH-1:0]    SrcA;
    logic [DATA_WIDTH-1:0]    SrcB;
    logic [OPCODE_LENGTH-1:0] Operation;

    modport master (
        output in_valid, opcode, funct3, funct7, rs1_data, rs2_data, imm, out_ready,
        input  in_ready, out_valid, SrcA, SrcB, Operation
    );

    modport slave (
        input  in_valid, opcode, funct3, funct7, rs1_data, rs2_data, imm, out_ready,
        output in_ready, out_valid, SrcA, SrcB, Operation
    );
endinterface

// File: rtl/alu_issue_skid.sv
// Two-entry valid/ready skid buffer on alu_req_t; all outputs, including
// in_ready, come straight from flops.
module alu_issue_skid
    import alu_pkg::*;
(
    input  logic     clk,
    input  logic     rst_n,
    input  logic     in_valid,
    output logic     in_ready,
    input  alu_req_t in_data,
    output logic     out_valid,
    input  logic     out_ready,
    output alu_req_t out_data
);
    logic     main_v_r, skid_v_r, in_ready_r;
    alu_req_t main_d_r, skid_d_r;
    logic     main_v_s, skid_v_s;
    alu_req_t main_d_s, skid_d_s;

    // Next-state: skid drains into main first; otherwise input goes to main
    // when main is free or leaving, else parks in the skid entry.
    always_comb begin
        main_v_s = main_v_r;
        main_d_s = main_d_r;
        skid_v_s = skid_v_r;
        skid_d_s = skid_d_r;
        if (skid_v_r) begin
            if (out_ready) begin
                main_d_s = skid_d_r;
                skid_v_s = 1'b0;
            end else begin
                main_d_s = main_d_r;
            end
        end else if (in_valid) begin
            if (!main_v_r || out_ready) begin
                main_v_s = 1'b1;
                main_d_s = in_data;
            end else begin
                skid_v_s = 1'b1;
                skid_d_s = in_data;
            end
        end else begin
            if (out_ready) begin
                main_v_s = 1'b0;
            end else begin
                main_v_s = main_v_r;
            end
        end
    end

    // Buffer state; in_ready is precomputed so it never depends on out_ready combinationally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_v_r   <= 1'b0;
            skid_v_r   <= 1'b0;
            in_ready_r <= 1'b1;
            main_d_r   <= {$bits(alu_req_t){1'b0}};
            skid_d_r   <= {$bits(alu_req_t){1'b0}};
        end else begin
            main_v_r   <= main_v_s;
            skid_v_r   <= skid_v_s;
            in_ready_r <= ~skid_v_s;
            main_d_r   <= main_d_s;
            skid_d_r   <= skid_d_s;
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = main_v_r;
    assign out_data  = main_d_r;
endmodule

// File: rtl/alu_issue.sv
// Issue stage in front of the ALU: decodes RV32I fields into an ALU op and operands.
// Optional feature macro: ALU_ISSUE_ILLEGAL_EN adds the sticky illegal_seen output.
module alu_issue
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int OPCODE_LENGTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    alu_issue_if.slave   bus
`ifdef ALU_ISSUE_ILLEGAL_EN
    ,
    output logic         illegal_seen
`endif
);
    logic [OPCODE_LENGTH-1:0] op_s;
    logic [DATA_WIDTH-1:0]    srca_s, srcb_s;
    logic                     legal_s, use_imm_s;
    alu_req_t                 req_s, out_s;
    logic                     unused_funct7_s;

    assign unused_funct7_s = ^{bus.funct7[6], bus.funct7[4:0]};

    // Decode opcode/funct3/funct7[5] into an ALU op and operand-B source.
    always_comb begin
        op_s      = ALU_ILLEGAL;
        legal_s   = 1'b0;
        use_imm_s = 1'b0;
        case (bus.opcode)
            OPC_RTYPE: begin
                legal_s = 1'b1;
                case (bus.funct3)
                    3'b000:  op_s = bus.funct7[5] ? ALU_SUB : ALU_ADD;
                    3'b111:  op_s = ALU_AND;
                    3'b110:  op_s = ALU_OR;
                    3'b100:  op_s = ALU_XOR;
                    default: legal_s = 1'b0;
                endcase
            end
            OPC_IALU: begin
                legal_s   = 1'b1;
                use_imm_s = 1'b1;
                case (bus.funct3)
                    3'b000:  op_s = ALU_ADD;
                    3'b111:  op_s = ALU_AND;
                    3'b110:  op_s = ALU_OR;
                    3'b100:  op_s = ALU_XOR;
                    default: legal_s = 1'b0;
                endcase
            end
            OPC_BRANCH: begin
                legal_s = 1'b1;
                case (bus.funct3)
                    3'b000:  op_s = ALU_EQ;
                    3'b001:  op_s = ALU_NE;
                    3'b100:  op_s = ALU_LT;
                    3'b101:  op_s = ALU_GE;
                    default: legal_s = 1'b0;
                endcase
            end
            OPC_LOAD, OPC_STORE: begin
                legal_s   = 1'b1;
                use_imm_s = 1'b1;
                op_s      = ALU_ADD;
            end
            OPC_LUI, OPC_JAL: begin
                legal_s   = 1'b1;
                use_imm_s = 1'b1;
                op_s      = ALU_PASS1;
            end
            default: legal_s = 1'b0;
        endcase
        if (legal_s) begin
            srca_s = bus.rs1_data;
            srcb_s = use_imm_s ? bus.imm : bus.rs2_data;
        end else begin
            srca_s = {DATA_WIDTH{1'b0}};
            srcb_s = {DATA_WIDTH{1'b0}};
            op_s   = ALU_ILLEGAL;
        end
    end

    // Illegal requests collapse to the canonical zero-operand ILLEGAL payload.
    always_comb begin
        if (legal_s) begin
            req_s.srca = srca_s;
            req_s.srcb = srcb_s;
            req_s.op   = op_s;
        end else begin
            req_s = illegal_req();
        end
    end

    alu_issue_skid u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (bus.in_valid),
        .in_ready  (bus.in_ready),
        .in_data   (req_s),
        .out_valid (bus.out_valid),
        .out_ready (bus.out_ready),
        .out_data  (out_s)
    );

    assign bus.SrcA      = out_s.srca;
    assign bus.SrcB      = out_s.srcb;
    assign bus.Operation = out_s.op;

`ifdef ALU_ISSUE_ILLEGAL_EN
    logic illegal_seen_r;

    // Sticky: set when an illegal request is accepted, cleared only by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            illegal_seen_r <= 1'b0;
        end else if (bus.in_valid && bus.in_ready && !legal_s) begin
            illegal_seen_r <= 1'b1;
        end else begin
            illegal_seen_r <= illegal_seen_r;
        end
    end

    assign illegal_seen = illegal_seen_r;
`endif
endmodule
